// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: sequences start, data, optional parity and stop
// bits around an external shift register that supplies the serial data bits.
module uart_tx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  TX_OUT,
    output logic                  tx_done
);

    localparam int unsigned ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept_c;
    logic data_xor;
    logic par_en_q;
    logic par_typ_q;
    logic par_bit_c;

    assign accept_c = Data_Valid && !busy;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame settings captured on the acceptance edge so later input changes cannot leak in
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_xor  <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (accept_c) begin
            data_xor  <= ^P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    // Odd parity is the inverted data XOR
    assign par_bit_c = data_xor ^ par_typ_q;

    // Next-state logic
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:   state_nxt = accept_c ? S_START : S_IDLE;
            S_START:  state_nxt = S_DATA;
            S_DATA: begin
                if (ser_done) begin
                    state_nxt = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    state_nxt = S_DATA;
                end
            end
            S_PARITY: state_nxt = S_STOP;
            S_STOP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        ser_en  = 1'b0;
        busy    = (state != S_IDLE);
        TX_OUT  = 1'b1;
        tx_done = 1'b0;
        case (state)
            S_START: begin
                ser_en = 1'b1;
                TX_OUT = 1'b0;
            end
            S_DATA: begin
                ser_en = 1'b1;
                TX_OUT = ser_data;
            end
            S_PARITY: TX_OUT = par_bit_c;
            S_STOP:   tx_done = 1'b1;
            default:  TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: frame-level queue model checked every cycle, with directed
// frames followed by randomized traffic.
module tb_uart_tx_fsm;

    localparam int unsigned DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          ser_data;
    logic          ser_done;
    logic          ser_en;
    logic          busy;
    logic          TX_OUT;
    logic          tx_done;

    always #5 CLK = ~CLK;

    uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .busy       (busy),
        .TX_OUT     (TX_OUT),
        .tx_done    (tx_done)
    );

    // Downstream shift register stub; a zero pad in bit 0 so DATA cycle k shows bit k-1
    logic [DW:0]     sr_bits = '0;
    int unsigned     sr_cnt  = 0;
    logic            sd_block = 1'b0;
    logic            sd_force = 1'b0;

    always @(posedge CLK) begin
        if (Data_Valid && !busy) begin
            sr_bits <= {P_DATA, 1'b0};
            sr_cnt  <= 0;
        end else if (ser_en) begin
            sr_bits <= sr_bits >> 1;
            sr_cnt  <= sr_cnt + 1;
        end
    end

    assign ser_data = sr_bits[0];
    assign ser_done = ((sr_cnt == DW) && !sd_block) || sd_force;

    // Reference model: one queue entry per expected frame cycle
    typedef struct packed {
        logic tx;
        logic en;
        logic done;
        logic dat;
    } exp_t;

    exp_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [15:0] hist     = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (q.size() != 0) begin
            e = q[0];
        end else begin
            e = '{tx: 1'b1, en: 1'b0, done: 1'b0, dat: 1'b0};
        end
        hist = {hist[14:0], TX_OUT};
        check("tx_out",  32'(TX_OUT),  32'(e.tx));
        check("busy",    32'(busy),    32'(q.size() != 0));
        check("ser_en",  32'(ser_en),  32'(e.en));
        check("tx_done", 32'(tx_done), 32'(e.done));
    endtask

    task automatic model_step(input logic dv, input logic [DW-1:0] d, input logic pe, input logic pt);
        logic [DW-1:0] t;
        if (q.size() != 0) begin
            void'(q.pop_front());
        end else if (dv) begin
            t = d;
            q.push_back('{tx: 1'b0, en: 1'b1, done: 1'b0, dat: 1'b0});
            for (int i = 0; i < int'(DW); i++) begin
                q.push_back('{tx: t[0], en: 1'b1, done: 1'b0, dat: 1'b1});
                t = t >> 1;
            end
            if (pe) begin
                q.push_back('{tx: (pt ? ~(^d) : ^d), en: 1'b0, done: 1'b0, dat: 1'b0});
            end
            q.push_back('{tx: 1'b1, en: 1'b0, done: 1'b1, dat: 1'b0});
        end
    endtask

    // Called at a falling edge: drive, check, advance the model, move to the next falling edge
    task automatic run_cycle(input logic dv, input logic [DW-1:0] d, input logic pe,
                             input logic pt, input logic frc);
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        sd_force   = frc && !(q.size() != 0 && q[0].dat);
        check_outputs();
        model_step(dv, d, pe, pt);
        @(negedge CLK);
    endtask

    task automatic reset_pulse();
        RST = 1'b0;
        #1;
        check("rst_tx",      32'(TX_OUT),  32'(1'b1));
        check("rst_busy",    32'(busy),    32'(1'b0));
        check("rst_ser_en",  32'(ser_en),  32'(1'b0));
        check("rst_tx_done", 32'(tx_done), 32'(1'b0));
        q.delete();
        #2;
        RST = 1'b1;
    endtask

    initial begin
        @(negedge CLK);
        check_outputs();
        @(negedge CLK);
        RST = 1'b1;

        // 0xA5 without parity, accepted on the first edge after reset release
        run_cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
        check("a5_frame", 32'(hist[9:0]), 32'(10'b0101001011));

        // 0xA5 with even then odd parity; PAR_TYP and P_DATA toggle after acceptance
        run_cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) run_cycle(1'b0, 8'($urandom), 1'b0, 1'(i), 1'b0);
        check("a5_even_par", 32'(hist[1]), 32'(1'b0));
        run_cycle(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) run_cycle(1'b0, 8'($urandom), 1'b0, 1'(i), 1'b0);
        check("a5_odd_par", 32'(hist[1]), 32'(1'b1));

        // 0x00 with odd parity
        run_cycle(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) run_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("zero_odd_frame", 32'(hist[10:0]), 32'(11'b00000000011));

        // Data_Valid held high: 0x3C, then 0xC3 appears mid-frame and must wait
        for (int i = 0; i < 6; i++) run_cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) run_cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        check("b2b_gap_frame2", 32'(hist[11:0]), 32'(12'b110110000111));
        run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset in DATA cycle 4, then a clean frame on the first edge after release
        run_cycle(1'b1, 8'($urandom), 1'b1, 1'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("pre_rst_ser_en", 32'(ser_en), 32'(1'b1));
        reset_pulse();
        run_cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // ser_done withheld: the frame stays in DATA indefinitely
        @(negedge CLK);
        sd_block = 1'b1;
        run_cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            Data_Valid = 1'($urandom);
            @(negedge CLK);
        end
        check("stall_busy",    32'(busy),    32'(1'b1));
        check("stall_ser_en",  32'(ser_en),  32'(1'b1));
        check("stall_tx_done", 32'(tx_done), 32'(1'b0));
        reset_pulse();
        sd_block = 1'b0;

        // Randomized traffic, including stray ser_done outside DATA
        for (int i = 0; i < 400; i++) begin
            run_cycle(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
